// File: rtl/rf_writeback_buffer_pkg.sv
// Shared defaults for the register-file writeback path, so the buffer and
// register_file agree on data width, address width and the zero register.
package rf_writeback_buffer_pkg;

   localparam int         WORD               = 8;
   localparam int         SPEC_WIDTH         = 4 * WORD;
   localparam int         SPEC_ADDR_SPACE    = 5;
   localparam int         SPEC_REG_AMOUNT    = 32;
   localparam logic [4:0] SPEC_ZERO_REGISTER = 5'b00000;
   localparam int         SPEC_DEPTH         = 4;

endpackage

// File: rtl/rf_writeback_buffer_wb_fifo.sv
// In-order writeback queue: storage, head/tail/count and per-entry valid bits,
// with every entry and its age order exposed for the bypass search.
module wb_fifo
   import rf_writeback_buffer_pkg::*;
#(
   parameter  int WIDTH = SPEC_WIDTH,
   parameter  int AW    = SPEC_ADDR_SPACE,
   parameter  int DEPTH = SPEC_DEPTH,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  logic [AW-1:0]          push_addr_i,
   input  logic [WIDTH-1:0]       push_data_i,
   input  logic                   pop_i,
   output logic [AW-1:0]          head_addr_o,
   output logic [WIDTH-1:0]       head_data_o,
   output logic [CW-1:0]          count_o,
   output logic [DEPTH-1:0]       ent_vld_o,
   output logic [DEPTH*AW-1:0]    ent_addr_o,
   output logic [DEPTH*WIDTH-1:0] ent_data_o,
   output logic [DEPTH*PW-1:0]    age_order_o
);

   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [AW-1:0]    addr_q [DEPTH];
   logic [WIDTH-1:0] data_q [DEPTH];

   // The caller never pushes when full nor pops when empty, so head and tail
   // never name the same slot in a cycle that does both.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      vld_d   = vld_q;
      count_d = count_q + CW'(push_i) - CW'(pop_i);
      if (push_i) begin
         vld_d[tail_q] = 1'b1;
         tail_d        = tail_q + PW'(1);
      end
      if (pop_i) begin
         vld_d[head_q] = 1'b0;
         head_d        = head_q + PW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         vld_q   <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         vld_q   <= vld_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) begin
         addr_q[tail_q] <= push_addr_i;
         data_q[tail_q] <= push_data_i;
      end
   end

   assign head_addr_o = addr_q[head_q];
   assign head_data_o = data_q[head_q];
   assign count_o     = count_q;
   assign ent_vld_o   = vld_q;

   // age_order_o slot k holds the physical index of the k-th oldest entry.
   for (genvar i = 0; i < DEPTH; i++) begin : g_flat
      assign ent_addr_o[i*AW +: AW]       = addr_q[i];
      assign ent_data_o[i*WIDTH +: WIDTH] = data_q[i];
      assign age_order_o[i*PW +: PW]      = head_q + PW'(i);
   end

endmodule

// File: rtl/rf_writeback_buffer.sv
// Writeback buffer in front of register_file: accepts results over valid/ready,
// drains one per cycle into the write port, and bypasses pending values to two readers.
module rf_writeback_buffer
   import rf_writeback_buffer_pkg::*;
#(
   parameter  int                    WIDTH         = SPEC_WIDTH,
   parameter  int                    ADDR_SPACE    = SPEC_ADDR_SPACE,
   parameter  int                    REG_AMOUNT    = SPEC_REG_AMOUNT,
   parameter  logic [ADDR_SPACE-1:0] ZERO_REGISTER = SPEC_ZERO_REGISTER,
   parameter  int                    DEPTH         = SPEC_DEPTH,
   localparam int                    PW            = $clog2(DEPTH),
   localparam int                    CW            = PW + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_SPACE-1:0] in_addr,
   input  logic [WIDTH-1:0]      in_data,
   input  logic                  drain_hold,
   output logic                  rf_wr_en,
   output logic [ADDR_SPACE-1:0] rf_wr_addr,
   output logic [WIDTH-1:0]      rf_wr_data,
   input  logic [ADDR_SPACE-1:0] q1_addr,
   output logic                  q1_hit,
   output logic [WIDTH-1:0]      q1_data,
   input  logic [ADDR_SPACE-1:0] q2_addr,
   output logic                  q2_hit,
   output logic [WIDTH-1:0]      q2_data,
   output logic [CW-1:0]         count
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   if (REG_AMOUNT > (1 << ADDR_SPACE) || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0)
   begin : g_bad_params
      $error("rf_writeback_buffer: inconsistent REG_AMOUNT/ADDR_SPACE or DEPTH");
   end

   logic                        push, pop;
   logic [ADDR_SPACE-1:0]       head_addr;
   logic [WIDTH-1:0]            head_data;
   logic [CW-1:0]               fifo_count;
   logic [DEPTH-1:0]            ent_vld;
   logic [DEPTH*ADDR_SPACE-1:0] ent_addr;
   logic [DEPTH*WIDTH-1:0]      ent_data;
   logic [DEPTH*PW-1:0]         age_order;

   logic                  wr_en_q, wr_en_d;
   logic [ADDR_SPACE-1:0] wr_addr_q, wr_addr_d;
   logic [WIDTH-1:0]      wr_data_q, wr_data_d;

   // Readiness uses the pre-edge count: a pop in the same cycle does not
   // open a slot, and zero-register writes are accepted but never queued.
   assign in_ready = rst && (fifo_count < DEPTH_C);
   assign push     = in_valid && in_ready && (in_addr != ZERO_REGISTER);
   assign pop      = rst && (fifo_count != '0) && !drain_hold;

   wb_fifo #(
      .WIDTH (WIDTH),
      .AW    (ADDR_SPACE),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i       (clk),
      .rst_ni      (rst),
      .push_i      (push),
      .push_addr_i (in_addr),
      .push_data_i (in_data),
      .pop_i       (pop),
      .head_addr_o (head_addr),
      .head_data_o (head_data),
      .count_o     (fifo_count),
      .ent_vld_o   (ent_vld),
      .ent_addr_o  (ent_addr),
      .ent_data_o  (ent_data),
      .age_order_o (age_order)
   );

   always_comb begin
      wr_en_d   = pop;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (pop) begin
         wr_addr_d = head_addr;
         wr_data_d = head_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign rf_wr_en   = wr_en_q;
   assign rf_wr_addr = wr_addr_q;
   assign rf_wr_data = wr_data_q;
   assign count      = fifo_count;

   logic [ADDR_SPACE-1:0] qaddr [2];
   assign qaddr[0] = q1_addr;
   assign qaddr[1] = q2_addr;

   // Scan oldest to youngest so the youngest match wins; the output stage
   // is seeded first as the lowest-priority source.
   for (genvar p = 0; p < 2; p++) begin : g_bypass
      logic             hit;
      logic [WIDTH-1:0] data;

      always_comb begin
         logic [PW-1:0] idx;
         hit  = 1'b0;
         data = '0;
         idx  = '0;
         if (rst && (qaddr[p] != ZERO_REGISTER)) begin
            if (wr_en_q && (wr_addr_q == qaddr[p])) begin
               hit  = 1'b1;
               data = wr_data_q;
            end
            for (int k = 0; k < DEPTH; k++) begin
               idx = age_order[k*PW +: PW];
               if (ent_vld[idx] && (ent_addr[idx*ADDR_SPACE +: ADDR_SPACE] == qaddr[p])) begin
                  hit  = 1'b1;
                  data = ent_data[idx*WIDTH +: WIDTH];
               end
            end
         end
      end
   end

   assign q1_hit  = g_bypass[0].hit;
   assign q1_data = g_bypass[0].data;
   assign q2_hit  = g_bypass[1].hit;
   assign q2_data = g_bypass[1].data;

endmodule

// File: tb/tb_rf_writeback_buffer.sv
// Directed bench for rf_writeback_buffer: a table of per-cycle vectors plus
// hand-written sequences for full-with-pop and reset in mid-operation.
module tb_rf_writeback_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_addr;
   logic [31:0] in_data;
   logic        drain_hold;
   logic        rf_wr_en;
   logic [4:0]  rf_wr_addr;
   logic [31:0] rf_wr_data;
   logic [4:0]  q1_addr;
   logic        q1_hit;
   logic [31:0] q1_data;
   logic [4:0]  q2_addr;
   logic        q2_hit;
   logic [31:0] q2_data;
   logic [2:0]  count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rf_writeback_buffer dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_addr    (in_addr),
      .in_data    (in_data),
      .drain_hold (drain_hold),
      .rf_wr_en   (rf_wr_en),
      .rf_wr_addr (rf_wr_addr),
      .rf_wr_data (rf_wr_data),
      .q1_addr    (q1_addr),
      .q1_hit     (q1_hit),
      .q1_data    (q1_data),
      .q2_addr    (q2_addr),
      .q2_hit     (q2_hit),
      .q2_data    (q2_data),
      .count      (count)
   );

   // Register-file model fed by the write port.
   logic [31:0] rfm [32];
   always @(posedge clk) begin
      if (rst && rf_wr_en) rfm[rf_wr_addr] <= rf_wr_data;
   end

   typedef struct packed {
      logic        v;
      logic [4:0]  a;
      logic [31:0] d;
      logic        h;
      logic [4:0]  q1;
      logic [4:0]  q2;
      logic        rdy;
      logic        h1;
      logic [31:0] d1;
      logic        h2;
      logic [31:0] d2;
      logic [2:0]  cnt;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        rfc;
      logic [4:0]  rfa;
      logic [31:0] rfd;
   } vec_t;

   localparam int NV = 21;
   vec_t vecs [NV];

   function automatic vec_t mk(input int v, a, d, h, q1, q2, rdy, h1, d1, h2, d2,
                               cnt, we, wa, wd, rfc, rfa, rfd);
      vec_t r;
      r.v = 1'(v);     r.a = 5'(a);     r.d = 32'(d);   r.h = 1'(h);
      r.q1 = 5'(q1);   r.q2 = 5'(q2);   r.rdy = 1'(rdy);
      r.h1 = 1'(h1);   r.d1 = 32'(d1);  r.h2 = 1'(h2);  r.d2 = 32'(d2);
      r.cnt = 3'(cnt); r.we = 1'(we);   r.wa = 5'(wa);  r.wd = 32'(wd);
      r.rfc = 1'(rfc); r.rfa = 5'(rfa); r.rfd = 32'(rfd);
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
      drain_hold = 1'b0; q1_addr = '0; q2_addr = '0;

      //            v  a   d   h q1 q2   rdy h1 d1  h2 d2   cnt we wa wd   rfc rfa rfd
      vecs[0]  = mk(1, 3,  7,  0, 3, 0,  1, 0, 0,   0, 0,   1, 0, 0, 0,    0, 0, 0);
      vecs[1]  = mk(0, 0,  0,  0, 3, 3,  1, 1, 7,   1, 7,   0, 1, 3, 7,    0, 0, 0);
      vecs[2]  = mk(0, 0,  0,  0, 3, 4,  1, 1, 7,   0, 0,   0, 0, 3, 7,    1, 3, 7);
      vecs[3]  = mk(1, 5, 100, 1, 5, 6,  1, 0, 0,   0, 0,   1, 0, 3, 7,    0, 0, 0);
      vecs[4]  = mk(1, 5, 200, 1, 5, 6,  1, 1, 100, 0, 0,   2, 0, 3, 7,    0, 0, 0);
      vecs[5]  = mk(0, 0,  0,  1, 5, 6,  1, 1, 200, 0, 0,   2, 0, 3, 7,    0, 0, 0);
      vecs[6]  = mk(0, 0,  0,  0, 5, 5,  1, 1, 200, 1, 200, 1, 1, 5, 100,  0, 0, 0);
      vecs[7]  = mk(0, 0,  0,  0, 5, 7,  1, 1, 200, 0, 0,   0, 1, 5, 200,  0, 0, 0);
      vecs[8]  = mk(0, 0,  0,  0, 5, 0,  1, 1, 200, 0, 0,   0, 0, 5, 200,  1, 5, 200);
      vecs[9]  = mk(1, 0, 99,  0, 0, 5,  1, 0, 0,   0, 0,   0, 0, 5, 200,  0, 0, 0);
      vecs[10] = mk(0, 0,  0,  0, 0, 0,  1, 0, 0,   0, 0,   0, 0, 5, 200,  0, 0, 0);
      vecs[11] = mk(1, 1, 10,  1, 1, 2,  1, 0, 0,   0, 0,   1, 0, 5, 200,  0, 0, 0);
      vecs[12] = mk(1, 2, 20,  1, 1, 2,  1, 1, 10,  0, 0,   2, 0, 5, 200,  0, 0, 0);
      vecs[13] = mk(1, 3, 30,  1, 1, 2,  1, 1, 10,  1, 20,  3, 0, 5, 200,  0, 0, 0);
      vecs[14] = mk(1, 4, 40,  1, 1, 4,  1, 1, 10,  0, 0,   4, 0, 5, 200,  0, 0, 0);
      vecs[15] = mk(1, 6, 50,  1, 4, 3,  0, 1, 40,  1, 30,  4, 0, 5, 200,  0, 0, 0);
      vecs[16] = mk(0, 0,  0,  0, 6, 1,  0, 0, 0,   1, 10,  3, 1, 1, 10,   0, 0, 0);
      vecs[17] = mk(0, 0,  0,  0, 1, 0,  1, 1, 10,  0, 0,   2, 1, 2, 20,   1, 1, 10);
      vecs[18] = mk(0, 0,  0,  0, 3, 4,  1, 1, 30,  1, 40,  1, 1, 3, 30,   1, 2, 20);
      vecs[19] = mk(0, 0,  0,  0, 3, 4,  1, 1, 30,  1, 40,  0, 1, 4, 40,   0, 0, 0);
      vecs[20] = mk(0, 0,  0,  0, 4, 1,  1, 1, 40,  0, 0,   0, 0, 4, 40,   1, 4, 40);

      // Reset state, with a request and a query presented while in reset.
      in_valid = 1'b1; in_addr = 5'd9; in_data = 32'h55; q1_addr = 5'd9;
      repeat (2) tick();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_q1_hit",   32'(q1_hit),   32'd0);
      chk("rst_count",    32'(count),    32'd0);
      chk("rst_wr_en",    32'(rf_wr_en), 32'd0);
      chk("rst_wr_addr",  32'(rf_wr_addr), 32'd0);
      chk("rst_wr_data",  rf_wr_data,    32'd0);
      rst = 1'b1; in_valid = 1'b0;
      tick();

      for (int i = 0; i < NV; i++) begin
         in_valid = vecs[i].v; in_addr = vecs[i].a; in_data = vecs[i].d;
         drain_hold = vecs[i].h; q1_addr = vecs[i].q1; q2_addr = vecs[i].q2;
         #1;
         chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
         chk($sformatf("v%0d_q1_hit", i),   32'(q1_hit),   32'(vecs[i].h1));
         chk($sformatf("v%0d_q1_data", i),  q1_data,       vecs[i].d1);
         chk($sformatf("v%0d_q2_hit", i),   32'(q2_hit),   32'(vecs[i].h2));
         chk($sformatf("v%0d_q2_data", i),  q2_data,       vecs[i].d2);
         tick();
         chk($sformatf("v%0d_count", i),    32'(count),      32'(vecs[i].cnt));
         chk($sformatf("v%0d_wr_en", i),    32'(rf_wr_en),   32'(vecs[i].we));
         chk($sformatf("v%0d_wr_addr", i),  32'(rf_wr_addr), 32'(vecs[i].wa));
         chk($sformatf("v%0d_wr_data", i),  rf_wr_data,      vecs[i].wd);
         if (vecs[i].rfc) chk($sformatf("v%0d_regfile", i), rfm[vecs[i].rfa], vecs[i].rfd);
      end

      // Full buffer with a simultaneous pop: no slot opens that cycle.
      drain_hold = 1'b1; in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_addr = 5'(8 + k); in_data = 32'(k + 1);
         tick();
      end
      chk("full_count", 32'(count), 32'd4);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      drain_hold = 1'b0; in_addr = 5'd12; in_data = 32'd5;
      #1;
      chk("fullpop_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("fullpop_count",   32'(count),      32'd3);
      chk("fullpop_wr_en",   32'(rf_wr_en),   32'd1);
      chk("fullpop_wr_addr", 32'(rf_wr_addr), 32'd8);
      chk("fullpop_wr_data", rf_wr_data,      32'd1);
      #1;
      chk("afterpop_in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("pushpop_count",   32'(count),      32'd3);
      chk("pushpop_wr_addr", 32'(rf_wr_addr), 32'd9);
      chk("pushpop_wr_data", rf_wr_data,      32'd2);
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("drain%0d_wr_en", k),   32'(rf_wr_en),   32'd1);
         chk($sformatf("drain%0d_wr_addr", k), 32'(rf_wr_addr), 32'(10 + k));
         chk($sformatf("drain%0d_wr_data", k), rf_wr_data,      32'(3 + k));
         chk($sformatf("drain%0d_count", k),   32'(count),      32'(2 - k));
      end
      tick();
      chk("drained_wr_en", 32'(rf_wr_en), 32'd0);

      // Reset with three entries queued: everything is dropped.
      drain_hold = 1'b1; in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_addr = 5'(13 + k); in_data = 32'(32'h130 + k);
         tick();
      end
      in_valid = 1'b0;
      chk("midrst_pre_count", 32'(count), 32'd3);
      rst = 1'b0; q1_addr = 5'd13; q2_addr = 5'd14;
      #1;
      chk("midrst_in_ready", 32'(in_ready), 32'd0);
      chk("midrst_q1_hit",   32'(q1_hit),   32'd0);
      chk("midrst_q2_hit",   32'(q2_hit),   32'd0);
      tick();
      chk("midrst_count",   32'(count),      32'd0);
      chk("midrst_wr_en",   32'(rf_wr_en),   32'd0);
      chk("midrst_wr_addr", 32'(rf_wr_addr), 32'd0);
      chk("midrst_wr_data", rf_wr_data,      32'd0);
      rst = 1'b1; drain_hold = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("postrst%0d_wr_en", k), 32'(rf_wr_en), 32'd0);
      end
      chk("postrst_count",  32'(count),  32'd0);
      chk("postrst_q1_hit", 32'(q1_hit), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rf_writeback_buffer.md
Name: rf_writeback_buffer

Overview:
- Write-side client of `register_file`.
- Accepts writeback results from the execute side over a valid/ready handshake and queues them in order in a small FIFO.
- Drains at most one entry per cycle into the register file's single write port (`wr_en`/`wr_addr`/`wr_data`).
- Provides two read-bypass lookups, so consumers see pending writes that the register file does not yet hold.

Parameters:
- WIDTH, 4*`WORD, data width; matches register_file WIDTH.
- ADDR_SPACE, 5, register address width.
- REG_AMOUNT, 32, number of architectural registers; informational only, not used for sizing logic.
- ZERO_REGISTER, 5'b00000, hardwired-zero register address.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  writeback request valid.
- in_ready  out  1  buffer can accept a request.
- in_addr  in  ADDR_SPACE  destination register.
- in_data  in  WIDTH  result value.
- drain_hold  in  1  freezes draining when 1.
- rf_wr_en  out  1  to register_file wr_en.
- rf_wr_addr  out  ADDR_SPACE  to register_file wr_addr.
- rf_wr_data  out  WIDTH  to register_file wr_data.
- q1_addr  in  ADDR_SPACE  bypass lookup address 1.
- q1_hit  out  1  a pending write to q1_addr exists.
- q1_data  out  WIDTH  youngest pending value for q1_addr; 0 when no hit.
- q2_addr  in  ADDR_SPACE  bypass lookup address 2.
- q2_hit  out  1  same as q1_hit, for q2_addr.
- q2_data  out  WIDTH  same as q1_data, for q2_addr.
- count  out  $clog2(DEPTH)+1  occupied FIFO entries.

Behaviour:
- Reset (rst==0 at an edge):
  - head, tail and count go to 0; all entry valid bits clear.
  - rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0.
  - Queued and in-flight entries are dropped, including in the middle of a burst.
  - While rst==0: in_ready=0, and q1_hit=q2_hit=0.
- Handshake:
  - A transfer occurs at the edge where in_valid && in_ready.
  - in_ready = rst && (count < DEPTH), computed from the pre-edge count.
  - When full, a same-cycle pop does not free a slot for that cycle; there is no pass-through.
  - in_addr==ZERO_REGISTER: the handshake completes and the request is discarded. Nothing is enqueued and count is unchanged.
- Drain:
  - At each edge, if count>0 and drain_hold==0, the head entry pops into the registered rf_wr_* outputs, and rf_wr_en=1 for the following cycle.
  - Otherwise rf_wr_en=0; rf_wr_addr and rf_wr_data hold their last values.
  - Each accepted non-zero request produces exactly one rf_wr_en pulse, in acceptance order. Duplicate addresses are written in order; no merging.
- Latency:
  - A request accepted at edge N into an empty buffer appears on rf_wr_* after edge N+1 and is written into register_file at edge N+2.
  - A request arriving during that cycle is not drained at that same edge.
- count:
  - Updates as count + push − pop.
  - A simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- Bypass (combinational):
  - Sources searched: all valid FIFO entries, plus the rf_wr_* stage while rf_wr_en==1.
  - Priority when several match: youngest FIFO entry first, then older entries, then the rf_wr_* stage.
  - The same-cycle in_* request is not visible to bypass.
  - A query for ZERO_REGISTER never hits.
  - No hit: data output is 0.

Decomposition:
- WIDTH, ADDR_SPACE, REG_AMOUNT and ZERO_REGISTER defaults come from the shared specs.vh; no local duplicates.
- One sub-module, `wb_fifo`:
  - contains storage, head/tail/count and the per-entry valid bits;
  - exposes all entries flattened, plus an age order, for the bypass search.
- The top level holds:
  - the handshake;
  - zero-register filtering;
  - the rf_wr_* output stage;
  - two instances of the priority-match logic, one per query port.

Test Plan:
- Reset then single write: after rst released, push (addr 3, data 7) at edge N → rf_wr_en=1, addr=3, data=7 after edge N+1; register_file r1 (r1_addr=3) reads 7 after edge N+2.
- Fill and backpressure: drain_hold=1, push addrs 1..4 with data 10..40 → count=4, in_ready=0. A fifth push is not accepted. Release hold → four consecutive rf_wr_en pulses with data 10, 20, 30, 40.
- Bypass priority: drain_hold=1, push (5, 100) then (5, 200); q1_addr=5 → q1_hit=1, q1_data=200. Query q2_addr=6 → q2_hit=0, q2_data=0.
- Zero register: push (0, 99) → handshake completes, count stays 0, no rf_wr_en pulse. q1_addr=0 → q1_hit=0.
- Full with simultaneous pop: count=DEPTH and draining → in_ready=0 that cycle; in_ready=1 the next cycle with count=DEPTH−1.
- Reset mid-operation: 3 entries queued with hold=1, rst=0 for one edge → count=0, rf_wr_en=0. No further writes occur after hold is released.
